// File: rtl/sevenseg_pkg.sv
// Purpose : shared types and constants for the seven-segment display driver.
// Contents: 7-bit segment vector type, 16-entry active-low glyph table,
//           dash / all-off / all-on patterns (all in active-low form).
package sevenseg_pkg;

    // Segment vector, bit6 = a ... bit0 = g.
    typedef logic [6:0] seg_t;

    // Active-low glyphs (1 = segment off) for values 0..F.
    localparam seg_t GLYPH_TABLE [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

    localparam seg_t SEG_DASH    = 7'b1111110; // only g lit
    localparam seg_t SEG_ALL_OFF = 7'b1111111;
    localparam seg_t SEG_ALL_ON  = 7'b0000000;

    // Convert an active-low pattern into the physical drive polarity.
    function automatic seg_t to_drive(input seg_t pat_low, input bit active_low);
        return active_low ? pat_low : ~pat_low;
    endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Purpose : bundle of display control inputs and the segment drive output.
// Ports   : num/en/blank/lamp_test driven by master, a_to_g driven by slave.
// Modports: master = display controller, slave = sevenseg driver.
interface sevenseg_if;
    import sevenseg_pkg::*;

    logic [3:0] num;
    logic       en;
    logic       blank;
    logic       lamp_test;
    seg_t       a_to_g;

    modport master (
        output num, en, blank, lamp_test,
        input  a_to_g
    );

    modport slave (
        input  num, en, blank, lamp_test,
        output a_to_g
    );

endinterface

// File: rtl/sevenseg_decode.sv
// Purpose : map a 4-bit value to its active-low glyph (hex or decimal+dash).
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of num.
module sevenseg_decode
    import sevenseg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b1
) (
    input  logic [3:0] num,
    output seg_t       glyph
);

    always_comb begin
        glyph = GLYPH_TABLE[num];
        // Decimal mode: anything above 9 is not a valid digit, show a dash.
        if (!HEX_MODE && (num >= 4'd10)) begin
            glyph = SEG_DASH;
        end
    end

endmodule

// File: rtl/sevenseg.sv
// Purpose : registered seven-segment driver with blank / lamp-test overrides.
// Latency : one cycle; a_to_g reflects inputs sampled at the previous edge.
// Backpressure: none; en qualifies loads, otherwise the output register holds.
// Ports   : clk, reset (sync, active-high), bus (slave modport of sevenseg_if).
module sevenseg
    import sevenseg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_MODE   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    sevenseg_if.slave   bus
);

    localparam seg_t SEG_RESET = to_drive(SEG_ALL_OFF, ACTIVE_LOW);

    seg_t glyph;
    seg_t pat_low;
    seg_t seg_d;
    seg_t seg_q;

    sevenseg_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .num   (bus.num),
        .glyph (glyph)
    );

    // Priority: lamp test beats blank beats the decoded digit. All work is
    // done in active-low form and converted to drive polarity at the end,
    // so overrides and dash follow the polarity parameter uniformly.
    always_comb begin
        pat_low = glyph;
        if (bus.lamp_test) begin
            pat_low = SEG_ALL_ON;
        end else if (bus.blank) begin
            pat_low = SEG_ALL_OFF;
        end

        seg_d = seg_q;
        if (bus.en) begin
            seg_d = to_drive(pat_low, ACTIVE_LOW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG_RESET;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.a_to_g = seg_q;

endmodule

// File: tb/tb_sevenseg.sv
// Purpose : self-checking bench for sevenseg in three parameterisations
//           (hex/active-low, decimal/active-low, hex/active-high).
// Method  : directed steps followed by random cycles against a reference model.
module tb_sevenseg;

    logic clk;
    logic reset;

    sevenseg_if if_hex ();
    sevenseg_if if_dec ();
    sevenseg_if if_pos ();

    sevenseg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) dut_hex (
        .clk (clk), .reset (reset), .bus (if_hex.slave));
    sevenseg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) dut_dec (
        .clk (clk), .reset (reset), .bus (if_dec.slave));
    sevenseg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) dut_pos (
        .clk (clk), .reset (reset), .bus (if_pos.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference glyphs taken directly from the display table, active-low.
    logic [6:0] ref_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic [6:0] exp_hex;
    logic [6:0] exp_dec;
    logic [6:0] exp_pos;

    // What the display should show (active-low) for one loaded sample.
    function automatic logic [6:0] ref_pat(input bit hex, input int n,
                                           input bit b, input bit l);
        if (l)                return 7'b0000000;
        if (b)                return 7'b1111111;
        if (!hex && n >= 10)  return 7'b1111110;
        return ref_tbl[n];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit e, input logic [3:0] n,
                         input bit b, input bit l);
        reset            = r;
        if_hex.en        = e; if_hex.num = n; if_hex.blank = b; if_hex.lamp_test = l;
        if_dec.en        = e; if_dec.num = n; if_dec.blank = b; if_dec.lamp_test = l;
        if_pos.en        = e; if_pos.num = n; if_pos.blank = b; if_pos.lamp_test = l;
    endtask

    // One clock: apply inputs mid-cycle, advance the model on the edge,
    // then compare all three instances just after the edge.
    task automatic cycle(input bit r, input bit e, input logic [3:0] n,
                         input bit b, input bit l, input string tag);
        @(negedge clk);
        drive(r, e, n, b, l);
        @(posedge clk);
        #1;
        if (r) begin
            exp_hex = 7'b1111111;
            exp_dec = 7'b1111111;
            exp_pos = 7'b0000000;
        end else if (e) begin
            exp_hex = ref_pat(1'b1, int'(n), b, l);
            exp_dec = ref_pat(1'b0, int'(n), b, l);
            exp_pos = ~ref_pat(1'b1, int'(n), b, l);
        end
        check({tag, "/hex"}, if_hex.a_to_g, exp_hex);
        check({tag, "/dec"}, if_dec.a_to_g, exp_dec);
        check({tag, "/pos"}, if_pos.a_to_g, exp_pos);
    endtask

    initial begin
        exp_hex = 'x; exp_dec = 'x; exp_pos = 'x;
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset for two cycles, then again with en and lamp_test held.
        cycle(1, 0, 4'd0, 0, 0, "rst0");
        cycle(1, 0, 4'd0, 0, 0, "rst1");
        check("rst_lit_hex", if_hex.a_to_g, 7'b1111111);
        check("rst_lit_pos", if_pos.a_to_g, 7'b0000000);
        cycle(1, 1, 4'd8, 0, 1, "rst_lamp0");
        cycle(1, 1, 4'd8, 0, 1, "rst_lamp1");
        check("rst_lamp_lit", if_hex.a_to_g, 7'b1111111);

        // Sweep 0..4 with literal spot checks.
        cycle(0, 1, 4'd0, 0, 0, "sweep0");
        check("sweep0_lit", if_hex.a_to_g, 7'b0000001);
        check("pos0_lit",   if_pos.a_to_g, 7'b1111110);
        cycle(0, 1, 4'd1, 0, 0, "sweep1");
        check("sweep1_lit", if_hex.a_to_g, 7'b1001111);
        cycle(0, 1, 4'd2, 0, 0, "sweep2");
        check("sweep2_lit", if_hex.a_to_g, 7'b0010010);
        cycle(0, 1, 4'd3, 0, 0, "sweep3");
        check("sweep3_lit", if_hex.a_to_g, 7'b0000110);
        cycle(0, 1, 4'd4, 0, 0, "sweep4");
        check("sweep4_lit", if_hex.a_to_g, 7'b1001100);

        // Full table, both modes.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 4'(i), 0, 0, $sformatf("table%0d", i));
        end
        check("dec15_dash_lit", if_dec.a_to_g, 7'b1111110);
        check("hexF_lit",       if_hex.a_to_g, 7'b0111000);

        // Hold: load 8, then en=0 with other values and overrides.
        cycle(0, 1, 4'd8, 0, 0, "hold_load");
        cycle(0, 0, 4'd1, 0, 0, "hold_num");
        check("hold_lit", if_hex.a_to_g, 7'b0000000);
        cycle(0, 0, 4'd1, 1, 0, "hold_blank");
        cycle(0, 0, 4'd3, 0, 1, "hold_lamp");

        // Overrides on 5.
        cycle(0, 1, 4'd5, 1, 0, "ovr_blank");
        check("ovr_blank_lit", if_hex.a_to_g, 7'b1111111);
        cycle(0, 1, 4'd5, 1, 1, "ovr_both");
        check("ovr_both_lit", if_hex.a_to_g, 7'b0000000);
        cycle(0, 1, 4'd5, 0, 0, "ovr_rel");
        check("ovr_rel_lit", if_hex.a_to_g, 7'b0100100);

        // Mid-operation reset blanks, first en edge afterwards loads.
        cycle(1, 1, 4'd7, 0, 0, "mid_rst");
        check("mid_rst_lit", if_hex.a_to_g, 7'b1111111);
        cycle(0, 0, 4'd7, 0, 0, "post_rst_hold");
        cycle(0, 1, 4'd7, 0, 0, "post_rst_load");
        check("post_rst_lit", if_hex.a_to_g, 7'b0001111);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sevenseg.md
SEVENSEG -- requirements
Module: sevenseg

Interface
REQ-001 Parameter ACTIVE_LOW, default 1: 1 = segment lit when its bit is 0 (common anode); 0 = lit when its bit is 1.
REQ-002 Parameter HEX_MODE, default 1: 1 = decode 0-F as hex glyphs; 0 = decimal mode, values 10-15 show a dash.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 num  input  4  digit value to display.
REQ-006 en  input  1  load enable; 1 = capture num into the output register this cycle.
REQ-007 blank  input  1  1 = all segments off.
REQ-008 lamp_test  input  1  1 = all segments on.
REQ-009 a_to_g  output  7  segment drive, registered: bit6 = a, bit5 = b, bit4 = c, bit3 = d, bit2 = e, bit1 = f, bit0 = g.

Function
REQ-010 Glyph table, active-low form (1 = off), a..g order:
- 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
- 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
- 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
- C = 0110001, d = 1000010, E = 0110000, F = 0111000
REQ-011 When ACTIVE_LOW = 0, a_to_g shall be the bitwise inverse of the REQ-010 pattern; this applies to every pattern, including dash, blank and lamp test.
REQ-012 When HEX_MODE = 0 and num >= 10, the glyph shall be a dash (g only lit: 1111110 active-low).
REQ-013 Latency: a_to_g shall reflect the inputs sampled at rising edge N, valid immediately after edge N; no combinational path from any input to a_to_g.
REQ-014 When en = 0 at an edge, a_to_g shall hold its previous value, regardless of num, blank or lamp_test.
REQ-015 When en = 1, priority shall be: lamp_test (all on), then blank (all off), then the decoded num glyph.
REQ-016 Simultaneous lamp_test = 1 and blank = 1 shall produce all segments on.
REQ-017 Every 4-bit num value shall have a defined output; there are no X or don't-care entries.

Reset
REQ-018 When reset = 1 at a rising edge, a_to_g shall go to all segments off (1111111 if ACTIVE_LOW = 1, 0000000 if ACTIVE_LOW = 0).
REQ-019 Reset shall have priority over en, lamp_test and blank.
REQ-020 After reset deasserts, the first edge with en = 1 shall load the normal REQ-015 result.
REQ-021 Asserting reset mid-operation shall blank the display on that edge.

Structure
REQ-022 A shared package shall hold:
- the 16-entry active-low glyph constant table;
- constants SEG_DASH, SEG_ALL_OFF and SEG_ALL_ON;
- a 7-bit segment vector typedef.
REQ-023 Sub-module sevenseg_decode: purely combinational; num plus HEX_MODE in, active-low glyph out.
REQ-024 The top level shall contain the priority mux, the polarity inversion and the single 7-bit output register.

Verification
REQ-025 Reset: reset = 1 for 2 cycles, then check a_to_g = 1111111 (ACTIVE_LOW = 1); repeat with en = 1 and lamp_test = 1 held during reset, same result.
REQ-026 Sweep: en = 1, num = 0,1,2,3,4 on successive cycles; one cycle later each, a_to_g = 0000001, 1001111, 0010010, 0000110, 1001100.
REQ-027 Full table: num 0-F in HEX_MODE = 1 matches REQ-010; with HEX_MODE = 0, num 10-15 gives 1111110.
REQ-028 Hold: load num = 8 (0000000), then en = 0 with num = 1; a_to_g stays 0000000.
REQ-029 Overrides: num = 5 with blank = 1 gives 1111111; add lamp_test = 1, gives 0000000; release both, gives 0100100.
REQ-030 Polarity: with ACTIVE_LOW = 0, num = 0 gives 1111110 and reset gives 0000000.
